ex_cond_ctrl: RTL

EX_COND_CTRL -- requirements
Module: ex_cond_ctrl

---
 rtl/ex_cond_ctrl_pkg.sv | 27 ++
 rtl/ex_cond_ctrl_cond_eval.sv | 38 +++
 rtl/ex_cond_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/ex_cond_ctrl_pkg.sv
// ex_cond_ctrl_pkg: shared pipeline encodings (COMB kinds, condition selects, EX control FSM states)
package ex_cond_ctrl_pkg;

    typedef enum logic [1:0] {
        COMB_ALU  = 2'b00,
        COMB_CMPB = 2'b01,
        COMB_ADDB = 2'b10,
        COMB_UB   = 2'b11
    } comb_e;

    typedef enum logic [2:0] {
        COND_NEVER = 3'b000,
        COND_EQ    = 3'b001,
        COND_LT    = 3'b010,
        COND_LE    = 3'b011,
        COND_LTU   = 3'b100,
        COND_LEU   = 3'b101,
        COND_OV    = 3'b110,
        COND_ODD   = 3'b111
    } cond_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_ANNUL = 1'b1
    } state_e;

endpackage

// File: rtl/ex_cond_ctrl_cond_eval.sv
// cond_eval: combinational condition evaluator
//   cond_in       : condition select
//   alu_z/n/v/c   : ALU zero, negative, overflow, carry flags
//   alu_odd       : ALU result LSB
//   cond_true     : selected condition holds
module cond_eval
    import ex_cond_ctrl_pkg::*;
(
    input  logic [2:0] cond_in,
    input  logic       alu_z,
    input  logic       alu_n,
    input  logic       alu_v,
    input  logic       alu_c,
    input  logic       alu_odd,
    output logic       cond_true
);

    logic lt;

    // signed less-than; carry clear means unsigned borrow
    assign lt = alu_n ^ alu_v;

    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(cond_in))
            COND_NEVER: cond_true = 1'b0;
            COND_EQ:    cond_true = alu_z;
            COND_LT:    cond_true = lt;
            COND_LE:    cond_true = lt | alu_z;
            COND_LTU:   cond_true = ~alu_c;
            COND_LEU:   cond_true = ~alu_c | alu_z;
            COND_OV:    cond_true = alu_v;
            COND_ODD:   cond_true = alu_odd;
            default:    cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_cond_ctrl.sv
// ex_cond_ctrl: EX-stage branch/nullify decision, annul FSM and PSW carry
//   clk, Reset               : clock, async active-high reset
//   EX_COMB_in, Cond_in      : instruction kind and condition select
//   N_in, EX_BL_in           : nullify bit, branch-and-link (not used for the decision)
//   EX_PSW_EN_in, EX_CO_EN_in: PSW carry load enable, carry-in enable
//   alu_z/n/v/c/odd, stall   : ALU flags, pipeline hold
//   branch_taken, flush_IF, squash_ID, annul_EX : control outputs
//   RF_LE_gate, RAM_WE_gate  : write gates for the EX instruction
//   psw_c, carry_in          : PSW carry and ALU carry-in
module ex_cond_ctrl
    import ex_cond_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       Reset,
    input  logic [1:0] EX_COMB_in,
    input  logic [2:0] Cond_in,
    input  logic       N_in,
    input  logic       EX_BL_in,
    input  logic       EX_PSW_EN_in,
    input  logic       EX_CO_EN_in,
    input  logic       alu_z,
    input  logic       alu_n,
    input  logic       alu_v,
    input  logic       alu_c,
    input  logic       alu_odd,
    input  logic       stall,
    output logic       branch_taken,
    output logic       flush_IF,
    output logic       squash_ID,
    output logic       annul_EX,
    output logic       RF_LE_gate,
    output logic       RAM_WE_gate,
    output logic       psw_c,
    output logic       carry_in
);

    state_e state_q, state_d;
    logic   psw_c_q, psw_c_d;
    logic   cond_true;
    logic   live;
    logic   unused_bl;

    assign unused_bl = EX_BL_in;

    cond_eval u_cond_eval (
        .cond_in  (Cond_in),
        .alu_z    (alu_z),
        .alu_n    (alu_n),
        .alu_v    (alu_v),
        .alu_c    (alu_c),
        .alu_odd  (alu_odd),
        .cond_true(cond_true)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_RUN;
            psw_c_q <= 1'b0;
        end else begin
            state_q <= state_d;
            psw_c_q <= psw_c_d;
        end
    end

    // An annulled instruction never branches or nullifies, so ANNUL always returns to RUN
    always_comb begin
        state_d = state_q;
        if (!stall)
            state_d = (state_q == ST_ANNUL) ? ST_RUN : (squash_ID ? ST_ANNUL : ST_RUN);
    end

    always_comb begin
        psw_c_d = (EX_PSW_EN_in && !annul_EX && !stall) ? alu_c : psw_c_q;
    end

    // Reset gating keeps the decode outputs quiet while Reset is held
    always_comb begin
        annul_EX     = (state_q == ST_ANNUL);
        live         = !annul_EX && !Reset;
        branch_taken = live && ((comb_e'(EX_COMB_in) == COMB_UB) ||
                       (((comb_e'(EX_COMB_in) == COMB_CMPB) || (comb_e'(EX_COMB_in) == COMB_ADDB)) && cond_true));
        flush_IF     = branch_taken;
        squash_ID    = live && N_in && (branch_taken || ((comb_e'(EX_COMB_in) == COMB_ALU) && cond_true));
        RF_LE_gate   = !annul_EX;
        RAM_WE_gate  = !annul_EX;
        psw_c        = psw_c_q;
        carry_in     = EX_CO_EN_in ? psw_c_q : 1'b0;
    end

endmodule
